// File: rtl/minmax_pkg.sv
// Shared types and default widths for the frame min/max tracker.
package minmax_pkg;

  localparam int unsigned W_DEF     = 4;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    S_FIRST   = 3'd0,
    S_WAIT    = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage : minmax_pkg

// File: rtl/minmax_seq_mag_cmp.sv
// W-bit unsigned magnitude comparator; exactly one of eq/gt/lt is high.
module mag_cmp #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  // Pure combinational compare of a against b.
  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule : mag_cmp

// File: rtl/minmax_seq.sv
// Frame min/max/count sequencer sharing one comparator between max and min passes.
module minmax_seq
  import minmax_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_max,
  output logic [W-1:0]     out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [W-1:0]     hold_q, hold_d;
  logic [W-1:0]     max_q, max_d;
  logic [W-1:0]     min_q, min_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             last_q, last_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     cmp_b;
  logic             cmp_eq, cmp_gt, cmp_lt;
  logic             accept;
  logic             upd_en;

  // Operand select: the held sample is compared against max, then against min.
  always_comb begin
    cmp_b = (state_q == S_CMP_MIN) ? min_q : max_q;
  end

  mag_cmp #(.W(W)) u_cmp (
    .a  (hold_q),
    .b  (cmp_b),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Update strobe for the active pass; ties never move max or min.
  always_comb begin
    accept = in_valid && in_ready_q;
    upd_en = !cmp_eq && ((state_q == S_CMP_MAX) ? cmp_gt : cmp_lt);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    max_d       = max_q;
    min_d       = min_q;
    count_d     = count_q;
    sat_d       = sat_q;
    last_d      = last_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      S_FIRST: begin
        if (accept) begin
          hold_d  = in_data;
          max_d   = in_data;
          min_d   = in_data;
          count_d = CNT_W'(1);
          sat_d   = 1'b0;
          state_d = in_last ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (accept) begin
          hold_d  = in_data;
          last_d  = in_last;
          state_d = S_CMP_MAX;
        end
      end
      S_CMP_MAX: begin
        if (upd_en) max_d = hold_q;
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        if (upd_en) min_d = hold_q;
        if (count_q == CNT_MAX) sat_d = 1'b1;
        else                    count_d = count_q + CNT_W'(1);
        state_d = last_q ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        if (out_ready) state_d = S_FIRST;
      end
      default: state_d = S_FIRST;
    endcase

    in_ready_d  = (state_d == S_FIRST) || (state_d == S_WAIT);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FIRST;
      hold_q      <= '0;
      max_q       <= '0;
      min_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      max_q       <= max_d;
      min_q       <= min_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;

endmodule : minmax_seq

// File: doc/minmax_seq.md
# minmax_seq

Frame-based min/max tracker that time-shares a single 4-bit magnitude comparator between a max-update and a min-update pass. It accepts a stream of unsigned samples over a valid/ready handshake, delimited by `in_last`. At end of frame it presents the maximum, minimum and sample count on a valid/ready result port. It sits downstream of any sample source in the comparator lecture designs and is the sequencer that drives the comparator datapath.

## Interface
- `W`, 4: sample width in bits (unsigned).
- `CNT_W`, 4: width of the sample counter.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on rising `clk`.
- `in_valid` input 1: sample present.
- `in_ready` output 1: block can accept a sample this cycle.
- `in_data` input W: sample value.
- `in_last` input 1: qualifies `in_data` as the final sample of the frame.
- `out_valid` output 1: frame result available.
- `out_ready` input 1: consumer accepts the result.
- `out_max` output W: largest sample in the frame.
- `out_min` output W: smallest sample in the frame.
- `out_count` output CNT_W: number of samples in the frame, saturating.
- `out_sat` output 1: the count saturated (frame longer than 2^CNT_W−1).

## Operation
- A transfer occurs when `valid && ready` on a rising edge. `in_data` and `in_last` are sampled only on that edge.
- State machine:
  - **S_FIRST**: `in_ready=1`. On accept: `max<=min<=hold<=in_data`, `count<=1`, `sat<=0`. Next state is S_DONE if `in_last`, else S_WAIT.
  - **S_WAIT**: `in_ready=1`. On accept: `hold<=in_data`, `last_q<=in_last`, then go to S_CMP_MAX. Otherwise stay.
  - **S_CMP_MAX**: `in_ready=0`. Comparator gets `a=hold`, `b=max`. If `gt`, `max<=hold`. Next state is S_CMP_MIN.
  - **S_CMP_MIN**: `in_ready=0`. Comparator gets `a=hold`, `b=min`. If `lt`, `min<=hold`. `count` increments, or sets `sat` if `count==2^CNT_W−1`. Next state is S_DONE if `last_q`, else S_WAIT.
  - **S_DONE**: `out_valid=1`, `in_ready=0`. On `out_ready`, go to S_FIRST.
- Comparator operand select is the only mux in front of the comparator. Equal operands (`eq`) never update `max` or `min`.
- Outputs `out_max`, `out_min`, `out_count` and `out_sat` are the internal registers. They are stable whenever `out_valid=1` and held until the handshake completes.
- Comparison is unsigned, full W bits. Counter arithmetic is unsigned CNT_W bits and never wraps.

## Timing
- Reset (`rst_n=0` at an edge): state S_FIRST, `in_ready=1` on the following cycle, `out_valid=0`. `out_max`, `out_min`, `out_count`, `hold` and `last_q` all reset to 0. `out_sat=0`.
- Reset mid-frame or during S_DONE aborts the frame. Partial results are discarded and no `out_valid` is produced.
- Per-sample cost after the first sample is 3 cycles (accept, CMP_MAX, CMP_MIN), so sustained input throughput is 1 sample per 3 cycles.
- Latency:
  - From accept of the `in_last` sample to `out_valid=1` is 3 cycles.
  - For a 1-sample frame it is 1 cycle.
- `in_ready` is a function of state only. It has no combinational path from `in_valid`.
- `out_valid` is registered and has no combinational path from `out_ready`.
- Back-to-back frames:
  - The next frame's first sample can be accepted the cycle after the result handshake.
  - `in_ready` is never high while `out_valid=1`.
- `in_valid` held while `in_ready=0` leaves the sample unconsumed. The source must hold `in_data` and `in_last` stable.

## Structure
- Shared package `minmax_pkg` holds:
  - the state enum (`S_FIRST`, `S_WAIT`, `S_CMP_MAX`, `S_CMP_MIN`, `S_DONE`);
  - default `W` and `CNT_W` constants.
- One sub-module, `mag_cmp`: parameterised W-bit unsigned comparator with outputs `eq`, `gt` and `lt`, exactly one of which is high. It is combinational and instantiated once.
- The top level holds the FSM, the `hold`, `max`, `min`, `count`, `sat` and `last_q` registers, and the operand mux.

## Test plan
- **Single-sample frame**: frame `{9, last}` → `out_valid` 1 cycle after accept with max=9, min=9, count=1, sat=0.
- **Mixed frame**: frame `3, 12, 0, 7(last)` → max=12, min=0, count=4; `in_ready` low for exactly 2 cycles after each non-first accept.
- **Equal values**: frame `5, 5, 5(last)` → max=5, min=5, count=3; no spurious updates.
- **Result backpressure**: hold `out_ready=0` for 5 cycles → outputs stable, `in_ready=0` throughout; the next frame's first sample is accepted the cycle after the handshake.
- **Counter saturation**: 17 samples of value 15 followed by `0(last)` with CNT_W=4 → count=15, sat=1, max=15, min=0.
- **Reset mid-frame**: assert `rst_n=0` for 1 cycle during S_CMP_MAX → all outputs 0, `in_ready=1` next cycle, no `out_valid`; the next frame `2(last)` returns max=min=2, count=1.
